muldiv_scheduler: RTL and testbench

Sequencer for the multiply/divide unit shared by the E stage of the 5-stage pipeline. Accepts one mult/div/mthi/mtlo request at a time and holds the HI/LO registers. Models the multi-cycle latency with a busy countdown. Drives the stall request the hazard logic uses to freeze D whenever a HI/LO-using instruction would meet an in-flight operation.

---
 rtl/muldiv_scheduler.sv | 155 +++++++++++++++
 tb/tb_muldiv_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_scheduler.sv
// Multiply/divide sequencer for the E stage: holds HI/LO, models multi-cycle latency, raises D-stage stall.
// Optional feature macro: MDU_CANCEL_EN (adds the Cancel port to abort an in-flight operation).
module muldiv_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel,
`endif
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        DUseMD,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MDStall
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = Cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Truncating the product of the 64-bit extended operands yields the exact 64-bit result.
  function automatic logic [63:0] mul_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] prod;
    ea   = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
    eb   = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
    prod = ea * eb;
    return prod;
  endfunction

  // Signed divide done on magnitudes so 0x80000000 / -1 needs no special path; returns {rem, quo}.
  function automatic logic [63:0] div_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [31:0] ma, mb, uq, ur, quo, rem;
    logic        na, nb;
    na  = sgn & a[31];
    nb  = sgn & b[31];
    ma  = na ? (~a + 32'd1) : a;
    mb  = nb ? (~b + 32'd1) : b;
    if (mb == 32'd0) mb = 32'd1;
    uq  = ma / mb;
    ur  = ma % mb;
    quo = (na ^ nb) ? (~uq + 32'd1) : uq;
    rem = na ? (~ur + 32'd1) : ur;
    return {rem, quo};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !cancel_w) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              {phi_d, plo_d} = mul_op(A, B, MDOp == OP_MULT);
              dz_d    = 1'b0;
              cnt_d   = MULT_LD;
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              {phi_d, plo_d} = div_op(A, B, MDOp == OP_DIV);
              dz_d    = (B == 32'd0);
              cnt_d   = DIV_LD;
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      default: begin
        if (cancel_w) begin
          cnt_d   = 4'd0;
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          if (!dz_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy    = (state_q == S_BUSY);
  assign HI      = hi_q;
  assign LO      = lo_q;
  // A mult/div starting in E counts as in flight for the D-stage instruction behind it.
  assign MDStall = DUseMD & (Busy | (Start & ~MDOp[2])) & ~cancel_w;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Scoreboarded bench for muldiv_scheduler: completions checked by a monitor on each Busy fall.
module tb_muldiv_scheduler;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        DUseMD;
  logic        Busy;
  logic [31:0] HI, LO;
  logic        MDStall;
`ifdef MDU_CANCEL_EN
  logic        Cancel;
`endif

  muldiv_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef MDU_CANCEL_EN
    .Cancel  (Cancel),
`endif
    .Start   (Start),
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .DUseMD  (DUseMD),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO),
    .MDStall (MDStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each Busy fall is a completion; compare HI/LO and the busy length with the queue head.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (Start) chk("start_while_busy", {31'd0, Busy}, 32'd0);
      if (prev_busy && !Busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_hi", HI, e.hi);
          chk("sb_lo", LO, e.lo);
          chk("sb_busy_cycles", 32'(busy_cnt), 32'(e.ncyc));
        end
        busy_cnt = 0;
      end
      if (Busy) busy_cnt++;
      prev_busy = Busy;
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h; e.lo = l; e.ncyc = n;
    sb.push_back(e);
  endtask

  // Called #1 after a rising edge; leaves Start low and scrambles operands after the Start edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!Busy) return;
      @(posedge clk); #1;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int stall_cnt;
    reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0; DUseMD = 1'b0;
`ifdef MDU_CANCEL_EN
    Cancel = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", {31'd0, MDStall}, 32'd0);

    // MULT -2*3 with an mflo right behind it in D
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    DUseMD = 1'b1; Start = 1'b1; MDOp = 3'd0; A = 32'hFFFF_FFFE; B = 32'd3;
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!MDStall) break;
      stall_cnt++;
      @(posedge clk); #1;
      Start = 1'b0; A = $urandom; B = $urandom;
    end
    chk("mflo_stall_cycles", 32'(stall_cnt), 32'd6);
    @(posedge clk); #1;
    DUseMD = 1'b0;
    wait_idle();

    push(32'h0000_0002, 32'hFFFF_FFFA, 5);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3); wait_idle();
    push(32'h4000_0000, 32'h0000_0000, 5);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000); wait_idle();

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_idle();
    push(32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'd7, 32'hFFFF_FFFE); wait_idle();
    push(32'h0000_0001, 32'h0000_0003, 10);
    issue(3'd3, 32'd7, 32'd2); wait_idle();
    push(32'h0000_0000, 32'h8000_0000, 10);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    push(32'h0000_0000, 32'h8000_0000, 10);
    issue(3'd2, 32'd1234, 32'd0); wait_idle();

    // MTHI / MTLO: single-cycle, no busy, no stall
    DUseMD = 1'b1; Start = 1'b1; MDOp = 3'd4; A = 32'h1234_5678;
    #2 chk("mthi_stall", {31'd0, MDStall}, 32'd0);
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    issue(3'd5, 32'hCAFE_BABE, 32'd0);
    chk("mtlo_lo", LO, 32'hCAFE_BABE);
    chk("mtlo_hi_kept", HI, 32'h1234_5678);

    Start = 1'b1; MDOp = 3'd7; A = 32'h5555_AAAA;
    #2 chk("rsvd_stall", {31'd0, MDStall}, 32'd0);
    @(posedge clk); #1;
    Start = 1'b0; DUseMD = 1'b0;
    chk("rsvd_busy", {31'd0, Busy}, 32'd0);
    chk("rsvd_hi", HI, 32'h1234_5678);
    chk("rsvd_lo", LO, 32'hCAFE_BABE);

`ifdef MDU_CANCEL_EN
    push(32'h1234_5678, 32'hCAFE_BABE, 2);
    issue(3'd0, 32'd9, 32'd9);
    @(posedge clk); #1;
    Cancel = 1'b1;
    @(posedge clk); #1;
    Cancel = 1'b0;
    chk("cancel_busy", {31'd0, Busy}, 32'd0);
    chk("cancel_hi", HI, 32'h1234_5678);
    chk("cancel_lo", LO, 32'hCAFE_BABE);
    repeat (8) @(posedge clk); #1;
    chk("cancel_no_resume", LO, 32'hCAFE_BABE);

    DUseMD = 1'b1; Cancel = 1'b1; Start = 1'b1; MDOp = 3'd4; A = 32'hDEAD_BEEF;
    #2 chk("startcancel_stall", {31'd0, MDStall}, 32'd0);
    @(posedge clk); #1;
    Start = 1'b0; Cancel = 1'b0; DUseMD = 1'b0;
    chk("startcancel_hi", HI, 32'h1234_5678);
    chk("startcancel_busy", {31'd0, Busy}, 32'd0);
`endif

    // Reset in the 3rd busy cycle of a DIV: everything clears before the next edge
    issue(3'd3, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("midrst_no_resume_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_no_resume_lo", LO, 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
